line_memory: RTL and testbench

Block-addressed backing memory that answers line requests from the cache's memory port. It sits at the far end of the cache-to-memory link. It accepts one whole-line read or write per handshake and returns read data after a fixed, programmable latency. It keeps per-line valid bits so that never-written lines read as zero, and it counts reads, writes and miss-triggered reads for performance checks.

---
 rtl/line_memory_pkg.sv | 16 +
 rtl/line_memory_if.sv | 25 ++
 rtl/line_memory_store.sv | 44 ++++
 rtl/line_memory.sv | 119 +++++++++++
 tb/tb_line_memory.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_memory_pkg.sv
// Shared defaults and types for the line-addressed backing memory.
package line_memory_pkg;

    localparam int DEF_LINE_BYTES = 16;
    localparam int DEF_ADDR_W     = 28;
    localparam int DEF_DEPTH      = 256;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef logic [DEF_LINE_BYTES-1:0][7:0] line_t;

endpackage

// File: rtl/line_memory_if.sv
// Cache-to-memory line request link. The cache side is the master.
interface line_memory_if #(
    parameter int LINE_BYTES = line_memory_pkg::DEF_LINE_BYTES,
    parameter int ADDR_W     = line_memory_pkg::DEF_ADDR_W
) ();

    logic                    req_valid;
    logic                    write;
    logic [ADDR_W-1:0]       addr;
    logic [LINE_BYTES*8-1:0] data_out;
    logic                    cache_miss;
    logic                    ready;
    logic [LINE_BYTES*8-1:0] data_in;

    modport master (
        output req_valid, write, addr, data_out, cache_miss,
        input  ready, data_in
    );

    modport slave (
        input  req_valid, write, addr, data_out, cache_miss,
        output ready, data_in
    );

endinterface

// File: rtl/line_memory_store.sv
// Single-port line array with per-line valid bits and a registered read port.
// Never-written lines read back as zero; the data array itself is not reset.
module line_store
    import line_memory_pkg::*;
#(
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int DEPTH      = DEF_DEPTH,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic                       re,
    input  logic [IDX_W-1:0]           idx,
    input  logic [LINE_BYTES-1:0][7:0] wdata,
    output logic [LINE_BYTES-1:0][7:0] rdata
);

    logic [LINE_BYTES-1:0][7:0] mem [DEPTH];
    logic [DEPTH-1:0]           valid;

    // Data array write; no reset so it maps onto plain storage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Valid bits and read register; a read of an invalid line returns zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            rdata <= '0;
        end else begin
            if (we) begin
                valid[idx] <= 1'b1;
            end
            if (re) begin
                rdata <= valid[idx] ? mem[idx] : '0;
            end
        end
    end

endmodule

// File: rtl/line_memory.sv
// Backing memory answering whole-line requests after a fixed latency,
// with saturating read/write/miss statistics.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LATENCY    = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    line_memory_if.slave     bus,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                     state_q;
    state_t                     state_d;
    logic                       accept;
    logic                       commit;
    logic [LAT_W-1:0]           lat_cnt;
    logic [IDX_W-1:0]           idx_q;
    logic                       write_q;
    logic [LINE_BYTES-1:0][7:0] data_q;
    logic [LINE_BYTES-1:0][7:0] rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: accept in IDLE, commit when the latency expires,
    // and wait in DONE for the requester to drop req_valid.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (lat_cnt == '0) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.req_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready   = (state_q != BUSY);
    assign bus.data_in = rdata;

    // Request latch and latency down-counter; upper address bits alias away.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            data_q  <= '0;
        end else if (accept) begin
            lat_cnt <= LAT_W'(LATENCY - 1);
            idx_q   <= bus.addr[IDX_W-1:0];
            write_q <= bus.write;
            data_q  <= bus.data_out;
        end else if (state_q == BUSY && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    // Saturating statistics, bumped on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count   <= '0;
            wr_count   <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (bus.write) begin
                if (~&wr_count) wr_count <= wr_count + 1'b1;
            end else begin
                if (~&rd_count) rd_count <= rd_count + 1'b1;
                if (bus.cache_miss && ~&miss_count) miss_count <= miss_count + 1'b1;
            end
        end
    end

    line_store #(
        .LINE_BYTES (LINE_BYTES),
        .DEPTH      (DEPTH)
    ) u_store (
        .clk   (clk),
        .rst   (rst),
        .we    (commit & write_q),
        .re    (commit & ~write_q),
        .idx   (idx_q),
        .wdata (data_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_line_memory.sv
// Scoreboard bench for line_memory: reference line model, expected read data
// queued at issue and popped when ready returns.
module tb_line_memory;
    import line_memory_pkg::*;

    localparam int LATENCY = 4;
    localparam int CNT_W   = 4;

    logic clk;
    logic rst;
    logic [CNT_W-1:0] rd_count, wr_count, miss_count;

    line_memory_if #(.LINE_BYTES(16), .ADDR_W(28)) bus ();

    line_memory #(
        .LINE_BYTES (16),
        .ADDR_W     (28),
        .DEPTH      (256),
        .LATENCY    (LATENCY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .miss_count (miss_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_accept = 0;

    line_t      exp_mem   [256];
    logic       exp_valid [256];
    line_t      exp_q     [$];
    logic [3:0] exp_rd, exp_wr, exp_miss;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) exp_valid[i] = 1'b0;
        exp_q.delete();
        exp_rd = '0; exp_wr = '0; exp_miss = '0;
    endtask

    task automatic issue(input logic wr, input logic [27:0] a, input line_t d, input logic miss);
        int    cycles;
        line_t prev;
        line_t exp;
        @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: got %b want 1", bus.ready);
        end
        bus.req_valid  = 1'b1;
        bus.write      = wr;
        bus.addr       = a;
        bus.data_out   = d;
        bus.cache_miss = miss;
        if (!wr) exp_q.push_back(exp_valid[a[7:0]] ? exp_mem[a[7:0]] : '0);
        prev = bus.data_in;
        @(posedge clk); #1;
        last_accept = cyc;
        if (wr) begin
            if (exp_wr != 4'hF) exp_wr++;
        end else begin
            if (exp_rd != 4'hF) exp_rd++;
            if (miss && exp_miss != 4'hF) exp_miss++;
        end
        n_checks++;
        if (bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_ready_low: got %b want 0", bus.ready);
        end
        // Requester wiggles its outputs after accept; the block must ignore them.
        bus.addr       = a ^ 28'h0ABCDEF;
        bus.data_out   = ~d;
        bus.write      = ~wr;
        bus.cache_miss = ~miss;
        cycles = 0;
        while (bus.ready !== 1'b1 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        n_checks++;
        if (cycles != LATENCY) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles want %0d", cycles, LATENCY);
        end
        if (!wr) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (bus.data_in !== exp) begin
                n_fail++;
                $display("FAIL read_data addr=%h: got %h want %h", a, bus.data_in, exp);
            end
        end else begin
            n_checks++;
            if (bus.data_in !== prev) begin
                n_fail++;
                $display("FAIL write_holds_data_in: got %h want %h", bus.data_in, prev);
            end
            exp_mem[a[7:0]]   = d;
            exp_valid[a[7:0]] = 1'b1;
        end
        n_checks++;
        if (rd_count !== exp_rd || wr_count !== exp_wr || miss_count !== exp_miss) begin
            n_fail++;
            $display("FAIL counters: got rd=%0d wr=%0d miss=%0d want rd=%0d wr=%0d miss=%0d",
                     rd_count, wr_count, miss_count, exp_rd, exp_wr, exp_miss);
        end
    endtask

    task automatic drop();
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.ready !== 1'b1 || bus.data_in !== '0 ||
            rd_count !== '0 || wr_count !== '0 || miss_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b data=%h rd=%0d wr=%0d miss=%0d want 1,0,0,0,0",
                     bus.ready, bus.data_in, rd_count, wr_count, miss_count);
        end
        issue(1'b0, 28'h5, '0, 1'b0);
        drop();
    endtask

    task automatic test_write_read();
        do_reset();
        issue(1'b1, 28'h12, 128'h00112233445566778899AABBCCDDEEFF, 1'b0);
        drop();
        issue(1'b0, 28'h12, '0, 1'b0);
        drop();
        n_checks++;
        if (bus.data_in !== 128'h00112233445566778899AABBCCDDEEFF) begin
            n_fail++;
            $display("FAIL wr_rd_value: got %h want 00112233445566778899aabbccddeeff", bus.data_in);
        end
    endtask

    task automatic test_alias();
        do_reset();
        issue(1'b1, 28'h012, 128'hA5A5_0001_DEAD_BEEF_1357_9BDF_0246_8ACE, 1'b0);
        drop();
        issue(1'b0, 28'h112, '0, 1'b0);
        drop();
        issue(1'b0, 28'hFFFF013, '0, 1'b1);
        drop();
        issue(1'b0, 28'hFFFF012, '0, 1'b0);
        drop();
    endtask

    task automatic test_back_to_back();
        int    first;
        line_t held;
        do_reset();
        issue(1'b1, 28'h20, 128'h0F0E0D0C0B0A09080706050403020100, 1'b0);
        first = last_accept;
        drop();
        issue(1'b0, 28'h20, '0, 1'b1);
        n_checks++;
        if (last_accept - first != LATENCY + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d want %0d", last_accept - first, LATENCY + 2);
        end
        n_checks++;
        if (miss_count !== 4'd1) begin
            n_fail++;
            $display("FAIL b2b_miss_count: got %0d want 1", miss_count);
        end
        held = bus.data_in;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.ready !== 1'b1 || rd_count !== exp_rd || bus.data_in !== held) begin
                n_fail++;
                $display("FAIL done_hold cycle %0d: got ready=%b rd=%0d want ready=1 rd=%0d",
                         i, bus.ready, rd_count, exp_rd);
            end
        end
        drop();
    endtask

    task automatic test_reset_abort();
        do_reset();
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.write      = 1'b1;
        bus.addr       = 28'h7;
        bus.data_out   = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;
        bus.cache_miss = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.ready !== 1'b1 || rd_count !== '0 || wr_count !== '0 || miss_count !== '0) begin
            n_fail++;
            $display("FAIL abort_state: got ready=%b rd=%0d wr=%0d miss=%0d want 1,0,0,0",
                     bus.ready, rd_count, wr_count, miss_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) exp_valid[i] = 1'b0;
        exp_rd = '0; exp_wr = '0; exp_miss = '0;
        issue(1'b0, 28'h7, '0, 1'b0);
        drop();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            issue(1'b0, 28'(i * 3), '0, 1'b1);
            drop();
        end
        n_checks++;
        if (rd_count !== 4'hF || miss_count !== 4'hF) begin
            n_fail++;
            $display("FAIL saturation: got rd=%h miss=%h want F,F", rd_count, miss_count);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.write      = 1'b0;
        bus.addr       = '0;
        bus.data_out   = '0;
        bus.cache_miss = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_write_read();
        test_alias();
        test_back_to_back();
        test_reset_abort();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
